vpu_src_port_fetch: RTL and testbench

- VPU-side initiator of the SRAM source-port read protocol. It accepts one operand-fetch request per instruction from the VPU request decoder.
- For each request it issues 1-3 SRAM vector reads and captures the fixed-latency read data. It then presents the assembled operands plus opcode to the execution pipeline through a valid/ready handshake.
- It sits between the VPU request interface and the ALU pipeline input. It is the counterpart of the SRAM read responder on the source port.

---
 rtl/vpu_src_port_fetch_if.sv | 46 ++++
 rtl/vpu_src_port_fetch.sv | 128 ++++++++++++
 tb/tb_vpu_src_port_fetch.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vpu_src_port_fetch_if.sv
// rtl/vpu_src_port_fetch_if.sv - request, SRAM read and operand-output signal bundle for the source-port fetch block
interface vpu_src_port_fetch_if #(
   parameter int DATA_WIDTH   = 512,
   parameter int ADDR_WIDTH   = 16,
   parameter int OPCODE_WIDTH = 5
);
   logic                    req_valid;
   logic                    req_ready;
   logic [OPCODE_WIDTH-1:0] req_opcode;
   logic [1:0]              req_num_src;
   logic [ADDR_WIDTH-1:0]   req_addr0;
   logic [ADDR_WIDTH-1:0]   req_addr1;
   logic [ADDR_WIDTH-1:0]   req_addr2;

   logic                    sram_rd_req;
   logic [ADDR_WIDTH-1:0]   sram_rd_addr;
   logic                    sram_rd_gnt;
   logic [DATA_WIDTH-1:0]   sram_rdata;

   logic                    op_valid;
   logic                    op_ready;
   logic [OPCODE_WIDTH-1:0] op_opcode;
   logic [DATA_WIDTH-1:0]   op_data0;
   logic [DATA_WIDTH-1:0]   op_data1;
   logic [DATA_WIDTH-1:0]   op_data2;

   // fetch block view
   modport master (
      input  req_valid, req_opcode, req_num_src, req_addr0, req_addr1, req_addr2,
      output req_ready,
      output sram_rd_req, sram_rd_addr,
      input  sram_rd_gnt, sram_rdata,
      output op_valid, op_opcode, op_data0, op_data1, op_data2,
      input  op_ready
   );

   // environment view: request decoder, SRAM responder and ALU pipeline
   modport slave (
      output req_valid, req_opcode, req_num_src, req_addr0, req_addr1, req_addr2,
      input  req_ready,
      input  sram_rd_req, sram_rd_addr,
      output sram_rd_gnt, sram_rdata,
      input  op_valid, op_opcode, op_data0, op_data1, op_data2,
      output op_ready
   );
endinterface

// File: rtl/vpu_src_port_fetch.sv
// rtl/vpu_src_port_fetch.sv - VPU operand fetch: issues up to 3 SRAM reads per request and presents operands to the ALU
module vpu_src_port_fetch #(
   parameter int DATA_WIDTH   = 512,
   parameter int ADDR_WIDTH   = 16,
   parameter int OPCODE_WIDTH = 5,
   parameter int RD_LATENCY   = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   vpu_src_port_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

   state_t                  state;
   state_t                  state_nxt;
   logic [OPCODE_WIDTH-1:0] opcode_q;
   logic [ADDR_WIDTH-1:0]   addr0_q;
   logic [ADDR_WIDTH-1:0]   addr1_q;
   logic [ADDR_WIDTH-1:0]   addr2_q;
   logic [1:0]              num_src_q;
   logic [1:0]              issue_idx;
   logic [1:0]              recv_cnt;
   logic [DATA_WIDTH-1:0]   data0_q;
   logic [DATA_WIDTH-1:0]   data1_q;
   logic [DATA_WIDTH-1:0]   data2_q;
   // each entry is {valid, slot index}; the last stage lines up with rdata on the bus
   logic [2:0]              track [RD_LATENCY];
   logic [ADDR_WIDTH-1:0]   cur_addr;
   logic                    accept;
   logic                    grant_fire;
   logic                    ret_valid;
   logic [1:0]              ret_idx;

   assign accept     = (state == IDLE) && bus.req_valid;
   assign grant_fire = (state == ISSUE) && bus.sram_rd_gnt;
   assign ret_valid  = track[RD_LATENCY-1][2];
   assign ret_idx    = track[RD_LATENCY-1][1:0];

   // select the address of the read currently being issued
   always_comb begin
      cur_addr = addr0_q;
      case (issue_idx)
         2'd1:    cur_addr = addr1_q;
         2'd2:    cur_addr = addr2_q;
         default: cur_addr = addr0_q;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (bus.req_valid) state_nxt = (bus.req_num_src == 2'd0) ? OUT : ISSUE;
         ISSUE: if (bus.sram_rd_gnt && (issue_idx == num_src_q - 2'd1)) state_nxt = WAIT;
         WAIT:  if (ret_valid && (recv_cnt + 2'd1 == num_src_q)) state_nxt = OUT;
         OUT:   if (bus.op_ready) state_nxt = IDLE;
      endcase
   end

   // latch the request and count issued / returned reads
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q  <= '0;
         addr0_q   <= '0;
         addr1_q   <= '0;
         addr2_q   <= '0;
         num_src_q <= 2'd0;
         issue_idx <= 2'd0;
         recv_cnt  <= 2'd0;
      end else if (accept) begin
         opcode_q  <= bus.req_opcode;
         addr0_q   <= bus.req_addr0;
         addr1_q   <= bus.req_addr1;
         addr2_q   <= bus.req_addr2;
         num_src_q <= bus.req_num_src;
         issue_idx <= 2'd0;
         recv_cnt  <= 2'd0;
      end else begin
         if (grant_fire) issue_idx <= issue_idx + 2'd1;
         if (ret_valid)  recv_cnt  <= recv_cnt + 2'd1;
      end
   end

   // return tracking pipe; cleared on reset so pre-reset returns are dropped
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < RD_LATENCY; i++) track[i] <= 3'b000;
      end else begin
         track[0] <= {grant_fire, issue_idx};
         for (int i = 1; i < RD_LATENCY; i++) track[i] <= track[i-1];
      end
   end

   // operand capture; unused slots stay zero because all slots clear on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data0_q <= '0;
         data1_q <= '0;
         data2_q <= '0;
      end else if (accept) begin
         data0_q <= '0;
         data1_q <= '0;
         data2_q <= '0;
      end else if (ret_valid) begin
         case (ret_idx)
            2'd0:    data0_q <= bus.sram_rdata;
            2'd1:    data1_q <= bus.sram_rdata;
            2'd2:    data2_q <= bus.sram_rdata;
            default: data0_q <= data0_q;
         endcase
      end
   end

   assign bus.req_ready    = (state == IDLE);
   assign bus.sram_rd_req  = (state == ISSUE);
   assign bus.sram_rd_addr = (state == ISSUE) ? cur_addr : '0;
   assign bus.op_valid     = (state == OUT);
   assign bus.op_opcode    = opcode_q;
   assign bus.op_data0     = data0_q;
   assign bus.op_data1     = data1_q;
   assign bus.op_data2     = data2_q;
endmodule

// File: tb/tb_vpu_src_port_fetch.sv
// tb/tb_vpu_src_port_fetch.sv - self-checking bench for vpu_src_port_fetch
module tb_vpu_src_port_fetch;
   localparam int DW = 512;
   localparam int AW = 16;
   localparam int OW = 5;
   localparam int L  = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   vpu_src_port_fetch_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW)) bus ();

   vpu_src_port_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OPCODE_WIDTH(OW), .RD_LATENCY(L)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      logic [OW-1:0] opcode;
      logic [1:0]    num_src;
      logic [AW-1:0] a0;
      logic [AW-1:0] a1;
      logic [AW-1:0] a2;
      int            stall_idx;
      int            stall_len;
      bit            rand_gnt;
      bit            rand_data;
      int            ready_delay;
      int            exp_lat;
   } vec_t;

   typedef struct {
      logic [OW-1:0] opcode;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
      logic [DW-1:0] d2;
   } exp_t;

   exp_t          sb_q[$];
   logic [AW-1:0] addr_q[$];
   logic [DW-1:0] mem [1024];
   logic          pv [L];
   logic [DW-1:0] pd [L];
   vec_t          vecs [12];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            grant_count = 0;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s", name);
   endtask

   function automatic logic [DW-1:0] tag_pattern(input logic [AW-1:0] a);
      logic [DW-1:0] r;
      for (int j = 0; j < 32; j++) r[j*16 +: 16] = {a[7:0], 8'(j)};
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_pattern();
      logic [DW-1:0] r;
      for (int j = 0; j < 32; j++) r[j*16 +: 16] = 16'($urandom);
      return r;
   endfunction

   // one clock: observe at the falling edge, then advance the SRAM responder after the rising edge
   task automatic step();
      logic          g;
      logic [DW-1:0] md;
      exp_t          e;
      @(negedge clk);
      g  = bus.sram_rd_req && bus.sram_rd_gnt;
      md = '0;
      if (g) begin
         grant_count++;
         md = mem[bus.sram_rd_addr[9:0]];
         if (addr_q.size() == 0) fail_now("spurious_read");
         else chk("rd_addr", DW'(bus.sram_rd_addr), DW'(addr_q.pop_front()));
      end
      if (bus.op_valid && bus.op_ready) begin
         if (sb_q.size() == 0) fail_now("spurious_op");
         else begin
            e = sb_q.pop_front();
            chk("op_opcode", DW'(bus.op_opcode), DW'(e.opcode));
            chk("op_data0", bus.op_data0, e.d0);
            chk("op_data1", bus.op_data1, e.d1);
            chk("op_data2", bus.op_data2, e.d2);
         end
      end
      @(posedge clk);
      #1;
      for (int i = L-1; i > 0; i--) begin
         pv[i] = pv[i-1];
         pd[i] = pd[i-1];
      end
      pv[0] = g;
      pd[0] = md;
      bus.sram_rdata = pv[L-1] ? pd[L-1] : rand_pattern();
   endtask

   task automatic run_req(input vec_t v, input int vid);
      exp_t          e;
      logic [AW-1:0] a [3];
      logic [DW-1:0] d [3];
      logic [DW-1:0] snap0;
      logic [DW-1:0] snap2;
      logic [OW-1:0] snapop;
      int            stall_left;
      int            first_valid;
      int            hold;
      int            g0;
      bit            done;
      a[0] = v.a0; a[1] = v.a1; a[2] = v.a2;
      for (int k = 0; k < 3; k++) begin
         d[k] = '0;
         if (k < int'(v.num_src)) begin
            mem[a[k][9:0]] = v.rand_data ? rand_pattern() : tag_pattern(a[k]);
            d[k] = mem[a[k][9:0]];
            addr_q.push_back(a[k]);
         end
      end
      e.opcode = v.opcode; e.d0 = d[0]; e.d1 = d[1]; e.d2 = d[2];
      sb_q.push_back(e);
      bus.req_valid   = 1'b1;
      bus.req_opcode  = v.opcode;
      bus.req_num_src = v.num_src;
      bus.req_addr0   = v.a0;
      bus.req_addr1   = v.a1;
      bus.req_addr2   = v.a2;
      bus.sram_rd_gnt = 1'b1;
      bus.op_ready    = 1'b1;
      chk($sformatf("req_ready_accept_v%0d", vid), DW'(bus.req_ready), DW'(1));
      step();
      bus.req_valid   = 1'b0;
      bus.req_opcode  = OW'($urandom);
      bus.req_num_src = 2'($urandom);
      bus.req_addr0   = AW'($urandom);
      g0 = grant_count;
      stall_left = v.stall_len;
      first_valid = -1;
      hold = 0;
      done = 1'b0;
      snap0 = '0; snap2 = '0; snapop = '0;
      for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
         if (bus.sram_rd_req && (grant_count - g0) == v.stall_idx && stall_left > 0) begin
            bus.sram_rd_gnt = 1'b0;
            stall_left--;
            if (addr_q.size() > 0) chk($sformatf("stall_addr_hold_v%0d", vid), DW'(bus.sram_rd_addr), DW'(addr_q[0]));
         end else if (v.rand_gnt) bus.sram_rd_gnt = 1'($urandom_range(0, 1));
         else bus.sram_rd_gnt = 1'b1;
         if (bus.op_valid) begin
            if (first_valid < 0) begin
               first_valid = cyc;
               snap0 = bus.op_data0; snap2 = bus.op_data2; snapop = bus.op_opcode;
            end else begin
               chk($sformatf("hold_data0_v%0d", vid), bus.op_data0, snap0);
               chk($sformatf("hold_data2_v%0d", vid), bus.op_data2, snap2);
               chk($sformatf("hold_opcode_v%0d", vid), DW'(bus.op_opcode), DW'(snapop));
               chk($sformatf("hold_req_ready_v%0d", vid), DW'(bus.req_ready), DW'(0));
            end
            bus.op_ready = (hold >= v.ready_delay);
            hold++;
            if (bus.op_ready) done = 1'b1;
         end else begin
            bus.op_ready = 1'($urandom_range(0, 1));
         end
         step();
      end
      if (!done) fail_now($sformatf("timeout_v%0d", vid));
      if (v.exp_lat >= 0) chk($sformatf("latency_v%0d", vid), DW'(first_valid), DW'(v.exp_lat));
      chk($sformatf("grants_v%0d", vid), DW'(grant_count - g0), DW'(v.num_src));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            g_b2b;
      vec_t          vr;
      vecs[0] = '{5'd17, 2'd3, 16'h0010, 16'h0020, 16'h0030, -1, 0, 1'b0, 1'b0, 0, 6};
      vecs[1] = '{5'd9,  2'd2, 16'h0040, 16'h0050, 16'h0060,  1, 3, 1'b0, 1'b0, 0, 8};
      vecs[2] = '{5'd5,  2'd0, 16'h0011, 16'h0022, 16'h0033, -1, 0, 1'b0, 1'b0, 0, 1};
      vecs[3] = '{5'd3,  2'd1, 16'h0070, 16'h0071, 16'h0072, -1, 0, 1'b0, 1'b0, 0, 4};
      vecs[4] = '{5'd11, 2'd3, 16'h0080, 16'h0090, 16'h00a0, -1, 0, 1'b0, 1'b0, 10, 6};
      for (int i = 0; i < 7; i++)
         vecs[5+i] = '{OW'(20 + i), 2'd3, AW'(16'h100 + i*4), AW'(16'h101 + i*4), AW'(16'h102 + i*4),
                       -1, 0, 1'b1, 1'b1, 0, -1};

      rst_n = 1'b0;
      bus.req_valid = 1'b0; bus.req_opcode = '0; bus.req_num_src = 2'd0;
      bus.req_addr0 = '0; bus.req_addr1 = '0; bus.req_addr2 = '0;
      bus.sram_rd_gnt = 1'b0; bus.sram_rdata = '0; bus.op_ready = 1'b0;
      for (int i = 0; i < L; i++) begin pv[i] = 1'b0; pd[i] = '0; end
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", DW'(bus.req_ready), DW'(1));
      chk("rst_sram_rd_req", DW'(bus.sram_rd_req), DW'(0));
      chk("rst_sram_rd_addr", DW'(bus.sram_rd_addr), DW'(0));
      chk("rst_op_valid", DW'(bus.op_valid), DW'(0));
      chk("rst_op_opcode", DW'(bus.op_opcode), DW'(0));
      chk("rst_op_data0", bus.op_data0, '0);
      chk("rst_op_data1", bus.op_data1, '0);
      chk("rst_op_data2", bus.op_data2, '0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 5; i++) run_req(vecs[i], i);
      g_b2b = grant_count;
      for (int i = 5; i < 12; i++) run_req(vecs[i], i);
      chk("b2b_total_grants", DW'(grant_count - g_b2b), DW'(21));

      // reset in WAIT: read0 returns during reset, read1 returns after release
      mem[10'h200] = tag_pattern(16'h0200);
      mem[10'h210] = tag_pattern(16'h0210);
      addr_q.push_back(16'h0200);
      addr_q.push_back(16'h0210);
      bus.req_valid = 1'b1; bus.req_opcode = 5'd21; bus.req_num_src = 2'd2;
      bus.req_addr0 = 16'h0200; bus.req_addr1 = 16'h0210; bus.req_addr2 = 16'h0000;
      bus.sram_rd_gnt = 1'b1; bus.op_ready = 1'b0;
      step();
      bus.req_valid = 1'b0;
      step();
      step();
      rst_n = 1'b0;
      #1;
      chk("midrst_req_ready", DW'(bus.req_ready), DW'(1));
      chk("midrst_sram_rd_req", DW'(bus.sram_rd_req), DW'(0));
      chk("midrst_op_valid", DW'(bus.op_valid), DW'(0));
      chk("midrst_op_opcode", DW'(bus.op_opcode), DW'(0));
      step();
      rst_n = 1'b1;
      step();
      chk("late_ret_data0", bus.op_data0, '0);
      chk("late_ret_data1", bus.op_data1, '0);
      chk("late_ret_req_ready", DW'(bus.req_ready), DW'(1));
      chk("late_ret_op_valid", DW'(bus.op_valid), DW'(0));
      addr_q.delete();
      sb_q.delete();
      vr = '{5'd17, 2'd3, 16'h0300, 16'h0310, 16'h0320, -1, 0, 1'b0, 1'b0, 0, 6};
      run_req(vr, 12);

      chk("sb_empty", DW'(sb_q.size()), DW'(0));
      chk("addr_q_empty", DW'(addr_q.size()), DW'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
